// File: rtl/tb_exit_monitor_pkg.sv
// Shared types for the end-of-test monitor: verdict codes, their severity
// ordering, and the run-control state encoding.
package tb_exit_monitor_pkg;

    // Numeric order of the codes is the severity order (higher is worse).
    typedef enum logic [2:0] {
        STAT_RUNNING  = 3'd0,
        STAT_PASS     = 3'd1,
        STAT_EXIT_OK  = 3'd2,
        STAT_EXIT_ERR = 3'd3,
        STAT_FAIL     = 3'd4,
        STAT_TIMEOUT  = 3'd5
    } status_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Returns the more severe code; on a tie the first argument wins, which
    // lets a low-to-high channel scan keep the lowest index.
    function automatic status_e max_severity(input status_e a, input status_e b);
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/tb_exit_monitor_chan.sv
// One monitored channel: sticky done flag plus the result recorded on the
// first strobe cycle while recording is enabled.
module tb_exit_monitor_chan
    import tb_exit_monitor_pkg::*;
#(
    parameter int unsigned EXIT_VALUE_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        record_i,
    input  logic                        passed_i,
    input  logic                        failed_i,
    input  logic                        exit_valid_i,
    input  logic [EXIT_VALUE_WIDTH-1:0] exit_value_i,
    output logic                        event_o,
    output status_e                     eff_status_o,
    output logic [EXIT_VALUE_WIDTH-1:0] eff_value_o,
    output logic                        done_o
);

    logic                        done_q;
    status_e                     status_q;
    logic [EXIT_VALUE_WIDTH-1:0] value_q;
    status_e                     evt_status;
    logic [EXIT_VALUE_WIDTH-1:0] evt_value;

    // Decode this cycle's strobes: fail beats exit beats pass. Only an exit
    // carries a code; pass and fail results record zero.
    always_comb begin
        evt_status = STAT_PASS;
        evt_value  = '0;
        if (failed_i) begin
            evt_status = STAT_FAIL;
        end else if (exit_valid_i) begin
            evt_status = (exit_value_i == '0) ? STAT_EXIT_OK : STAT_EXIT_ERR;
            evt_value  = exit_value_i;
        end
    end

    // Result as seen at this cycle's edge: recorded one, else a fresh event.
    always_comb begin
        event_o      = record_i && !done_q && (passed_i || failed_i || exit_valid_i);
        eff_status_o = STAT_RUNNING;
        eff_value_o  = '0;
        if (done_q) begin
            eff_status_o = status_q;
            eff_value_o  = value_q;
        end else if (event_o) begin
            eff_status_o = evt_status;
            eff_value_o  = evt_value;
        end
    end

    // Capture the first event only; later strobes are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q   <= 1'b0;
            status_q <= STAT_RUNNING;
            value_q  <= '0;
        end else if (event_o) begin
            done_q   <= 1'b1;
            status_q <= evt_status;
            value_q  <= evt_value;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/tb_exit_monitor.sv
// Multi-channel end-of-test monitor: run FSM, cycle watchdog, drain window
// and a sticky registered verdict reduced across channels.
module tb_exit_monitor
    import tb_exit_monitor_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS     = 1,
    parameter int unsigned CYCLE_CNT_WIDTH  = 32,
    parameter int unsigned EXIT_VALUE_WIDTH = 32,
    parameter int unsigned DRAIN_CYCLES     = 4,
    parameter int unsigned WAIT_ALL         = 0
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              enable_i,
    input  logic [CYCLE_CNT_WIDTH-1:0]                        max_cycles_i,
    input  logic [NUM_CHANNELS-1:0]                           passed_i,
    input  logic [NUM_CHANNELS-1:0]                           failed_i,
    input  logic [NUM_CHANNELS-1:0]                           exit_valid_i,
    input  logic [NUM_CHANNELS-1:0][EXIT_VALUE_WIDTH-1:0]     exit_value_i,
    output logic [NUM_CHANNELS-1:0]                           chan_done_o,
    output status_e                                           status_o,
    output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] chan_o,
    output logic [EXIT_VALUE_WIDTH-1:0]                       exit_value_o,
    output logic [CYCLE_CNT_WIDTH-1:0]                        cycle_cnt_o,
    output logic                                              done_o
);

    localparam int unsigned CHAN_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_e                      state_q, state_d;
    logic [DRAIN_W-1:0]          drain_cnt_q;
    logic [CYCLE_CNT_WIDTH-1:0]  cycle_cnt_q;
    status_e                     status_q;
    logic [CHAN_W-1:0]           chan_q;
    logic [EXIT_VALUE_WIDTH-1:0] value_q;

    logic                        run;
    logic                        watchdog;
    logic                        term;
    logic [NUM_CHANNELS-1:0]     ch_evt;
    logic [NUM_CHANNELS-1:0]     ch_done;
    status_e                     eff_status [NUM_CHANNELS];
    logic [EXIT_VALUE_WIDTH-1:0] eff_value  [NUM_CHANNELS];
    status_e                     best_status;
    logic [CHAN_W-1:0]           best_chan;
    logic [EXIT_VALUE_WIDTH-1:0] best_value;

    assign run = (state_q == RUN);

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        tb_exit_monitor_chan #(
            .EXIT_VALUE_WIDTH(EXIT_VALUE_WIDTH)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .record_i     (run),
            .passed_i     (passed_i[g]),
            .failed_i     (failed_i[g]),
            .exit_valid_i (exit_valid_i[g]),
            .exit_value_i (exit_value_i[g]),
            .event_o      (ch_evt[g]),
            .eff_status_o (eff_status[g]),
            .eff_value_o  (eff_value[g]),
            .done_o       (ch_done[g])
        );
    end

    // Termination: watchdog first, else first event or all channels done.
    always_comb begin
        watchdog = (max_cycles_i != '0) && (cycle_cnt_q >= max_cycles_i);
        term     = 1'b0;
        if (run) begin
            if (watchdog) begin
                term = 1'b1;
            end else if (WAIT_ALL != 0) begin
                term = &(ch_done | ch_evt);
            end else begin
                term = |ch_evt;
            end
        end
    end

    // Most severe channel result, lowest index on ties; watchdog overrides.
    always_comb begin
        best_status = STAT_RUNNING;
        best_chan   = '0;
        best_value  = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (max_severity(best_status, eff_status[i]) != best_status) begin
                best_status = eff_status[i];
                best_chan   = CHAN_W'(i);
                best_value  = eff_value[i];
            end
        end
        if (watchdog) begin
            best_status = STAT_TIMEOUT;
            best_chan   = '0;
            best_value  = '0;
        end
    end

    // Next-state logic for the run control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i) state_d = RUN;
            RUN:     if (term) state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
            DRAIN:   if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Drain window counter: cleared while running, counts up in DRAIN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)               drain_cnt_q <= '0;
        else if (run)              drain_cnt_q <= '0;
        else if (state_q == DRAIN) drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
    end

    // Saturating count of RUN cycles, frozen after leaving RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                        cycle_cnt_q <= '0;
        else if (run && cycle_cnt_q != '1)  cycle_cnt_q <= cycle_cnt_q + CYCLE_CNT_WIDTH'(1);
    end

    // Verdict registers load once, on the terminating edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q <= STAT_RUNNING;
            chan_q   <= '0;
            value_q  <= '0;
        end else if (term) begin
            status_q <= best_status;
            chan_q   <= best_chan;
            value_q  <= best_value;
        end
    end

    assign chan_done_o  = ch_done;
    assign status_o     = status_q;
    assign chan_o       = chan_q;
    assign exit_value_o = value_q;
    assign cycle_cnt_o  = cycle_cnt_q;
    assign done_o       = (state_q == DONE);

endmodule
